zbt_sram_resp: RTL and testbench

- Synthesizable responder for the pipelined ZBT SRAM interface; it is the device end of the bus driven by the FPGA-side ZBT controller.
- Samples address and control on every clock and keeps an internal 36-bit memory array.
- Returns read data two cycles after the address cycle, and captures write data two cycles after the address cycle.
- Used as a loopback target in board-less bring-up and in regressions of the ZBT controller, with the bidirectional dq split into in/out/enable.

---
 rtl/zbt_sram_resp_pkg.sv | 22 ++
 rtl/zbt_burst_addr.sv | 51 +++++
 rtl/zbt_sram_resp.sv | 131 +++++++++++++
 tb/tb_zbt_sram_resp.sv | 273 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/zbt_sram_resp_pkg.sv
// Shared constants and helpers for the ZBT SRAM responder.
package zbt_sram_resp_pkg;

  localparam int unsigned DEF_ADDR_BITS = 16;
  localparam int unsigned DEF_DATA_BITS = 36;
  localparam int unsigned BYTE_BITS     = 9;
  localparam int unsigned NUM_BYTES     = 4;

  // Burst-order encodings carried on lbo_n.
  localparam logic LINEAR      = 1'b0;
  localparam logic INTERLEAVED = 1'b1;

  // Low two address bits of burst beat cnt starting at base.
  function automatic logic [1:0] burst_low(input logic [1:0] base, input logic [1:0] cnt,
                                           input logic lbo_n);
    logic [1:0] low;
    if (lbo_n == INTERLEAVED) low = base ^ cnt;
    else                      low = base + cnt;
    return low;
  endfunction

endpackage

// File: rtl/zbt_burst_addr.sv
// Command stage of the ZBT pipeline: holds base address, burst count, rw and selection.
module zbt_burst_addr
  import zbt_sram_resp_pkg::*;
#(
  parameter int unsigned ADDR_BITS = DEF_ADDR_BITS
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 en,
  input  logic                 load,
  input  logic                 sel,
  input  logic                 rw_n,
  input  logic                 lbo_n,
  input  logic [ADDR_BITS-1:0] addr,
  output logic [ADDR_BITS-1:0] burst_addr,
  output logic                 burst_rw_n,
  output logic                 burst_valid
);

  logic [ADDR_BITS-1:0] base_q;
  logic [1:0]           cnt_q;
  logic                 rw_q;
  logic                 sel_q;

  // Load a new base on ld_n=0 (or forced deselect), otherwise advance the beat counter.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      base_q <= '0;
      cnt_q  <= '0;
      rw_q   <= 1'b0;
      sel_q  <= 1'b0;
    end else if (en) begin
      if (load) begin
        base_q <= addr;
        cnt_q  <= '0;
        rw_q   <= rw_n;
        sel_q  <= sel;
      end else begin
        cnt_q <= cnt_q + 2'd1;
      end
    end
  end

  // Upper bits stay at the base; only the low two bits walk through the burst.
  always_comb begin
    burst_addr  = {base_q[ADDR_BITS-1:2], burst_low(base_q[1:0], cnt_q, lbo_n)};
    burst_rw_n  = rw_q;
    burst_valid = sel_q;
  end

endmodule

// File: rtl/zbt_sram_resp.sv
// ZBT SRAM device model: two-cycle pipelined read/write responder with byte-lane forwarding.
module zbt_sram_resp
  import zbt_sram_resp_pkg::*;
#(
  parameter int unsigned ADDR_BITS     = DEF_ADDR_BITS,
  parameter int unsigned DATA_BITS     = DEF_DATA_BITS,
  parameter int unsigned MEM_ADDR_BITS = 10
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [ADDR_BITS-1:0] addr,
  input  logic                 rw_n,
  input  logic                 ld_n,
  input  logic                 cke_n,
  input  logic                 ce_n,
  input  logic                 ce2,
  input  logic                 ce2_n,
  input  logic [3:0]           bw_n,
  input  logic                 lbo_n,
  input  logic                 oe_n,
  input  logic                 zz,
  input  logic [DATA_BITS-1:0] dq_in,
  output logic [DATA_BITS-1:0] dq_out,
  output logic                 dq_oe
);

  localparam int unsigned MemWords = 1 << MEM_ADDR_BITS;

  logic                     en;
  logic                     selected;
  logic                     cmd_load;
  logic                     cmd_sel;

  // Stage A (command edge)
  logic [ADDR_BITS-1:0]     a_addr;
  logic [MEM_ADDR_BITS-1:0] a_idx;
  logic                     a_rw_n;
  logic                     a_valid;
  logic [NUM_BYTES-1:0]     a_bw_q;

  // Stage B (one edge later)
  logic                     b_valid_q;
  logic                     b_rw_q;
  logic [MEM_ADDR_BITS-1:0] b_idx_q;
  logic [NUM_BYTES-1:0]     b_bw_q;

  logic [DATA_BITS-1:0]     mem [MemWords];
  logic [DATA_BITS-1:0]     rd_d;
  logic [DATA_BITS-1:0]     rd_q;
  logic                     rd_valid_q;
  logic                     commit;
  logic                     unused_addr_hi;

  // Command decode; sleep turns every command into a deselect.
  always_comb begin
    en       = ~cke_n;
    selected = ~ce_n & ce2 & ~ce2_n;
    cmd_load = ~ld_n | zz;
    cmd_sel  = ~ld_n & selected & ~zz;
  end

  zbt_burst_addr #(
    .ADDR_BITS (ADDR_BITS)
  ) u_burst_addr (
    .clk         (clk),
    .rst         (rst),
    .en          (en),
    .load        (cmd_load),
    .sel         (cmd_sel),
    .rw_n        (rw_n),
    .lbo_n       (lbo_n),
    .addr        (addr),
    .burst_addr  (a_addr),
    .burst_rw_n  (a_rw_n),
    .burst_valid (a_valid)
  );

  // Upper address bits alias onto the implemented depth.
  assign a_idx          = a_addr[MEM_ADDR_BITS-1:0];
  assign unused_addr_hi = ^a_addr[ADDR_BITS-1:MEM_ADDR_BITS];

  // A write in stage B commits on this edge; b_valid_q is cleared by reset so nothing commits then.
  assign commit = en & b_valid_q & ~b_rw_q;

  // Array read for the stage-A address, taking lanes from a write committing on the same edge.
  always_comb begin
    rd_d = mem[a_idx];
    if (commit && (b_idx_q == a_idx)) begin
      for (int i = 0; i < NUM_BYTES; i++) begin
        if (!b_bw_q[i]) rd_d[i*BYTE_BITS +: BYTE_BITS] = dq_in[i*BYTE_BITS +: BYTE_BITS];
      end
    end
  end

  // Array write and read-data register; contents survive reset.
  always_ff @(posedge clk) begin
    if (en) begin
      rd_q <= rd_d;
      if (commit) begin
        for (int i = 0; i < NUM_BYTES; i++) begin
          if (!b_bw_q[i]) mem[b_idx_q][i*BYTE_BITS +: BYTE_BITS] <= dq_in[i*BYTE_BITS +: BYTE_BITS];
        end
      end
    end
  end

  // Pipeline stage registers and output data; all hold while cke_n is high.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_bw_q     <= '1;
      b_valid_q  <= 1'b0;
      b_rw_q     <= 1'b0;
      b_idx_q    <= '0;
      b_bw_q     <= '1;
      rd_valid_q <= 1'b0;
      dq_out     <= '0;
    end else if (en) begin
      a_bw_q     <= bw_n;
      b_valid_q  <= a_valid;
      b_rw_q     <= a_rw_n;
      b_idx_q    <= a_idx;
      b_bw_q     <= a_bw_q;
      rd_valid_q <= b_valid_q & b_rw_q;
      if (b_valid_q && b_rw_q) dq_out <= rd_q;
    end
  end

  // Output enable is gated asynchronously by oe_n and sleep.
  assign dq_oe = rd_valid_q & ~oe_n & ~zz;

endmodule

// File: tb/tb_zbt_sram_resp.sv
// Directed self-checking bench for zbt_sram_resp.
module tb_zbt_sram_resp;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] addr;
  logic        rw_n, ld_n, cke_n, ce_n, ce2, ce2_n;
  logic [3:0]  bw_n;
  logic        lbo_n, oe_n, zz;
  logic [35:0] dq_in;
  logic [35:0] dq_out;
  logic        dq_oe;

  int tests_run    = 0;
  int tests_failed = 0;

  always #5 clk = ~clk;

  zbt_sram_resp dut (
    .clk    (clk),
    .rst    (rst),
    .addr   (addr),
    .rw_n   (rw_n),
    .ld_n   (ld_n),
    .cke_n  (cke_n),
    .ce_n   (ce_n),
    .ce2    (ce2),
    .ce2_n  (ce2_n),
    .bw_n   (bw_n),
    .lbo_n  (lbo_n),
    .oe_n   (oe_n),
    .zz     (zz),
    .dq_in  (dq_in),
    .dq_out (dq_out),
    .dq_oe  (dq_oe)
  );

  task automatic check_eq(input string tag, input logic [35:0] got, input logic [35:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_idle();
    ld_n = 1'b0;
    ce_n = 1'b1;
    rw_n = 1'b1;
    bw_n = 4'hF;
  endtask

  task automatic set_cmd(input logic rw, input logic [15:0] a, input logic [3:0] bw);
    ld_n  = 1'b0;
    ce_n  = 1'b0;
    ce2   = 1'b1;
    ce2_n = 1'b0;
    rw_n  = rw;
    addr  = a;
    bw_n  = bw;
  endtask

  task automatic do_write(input logic [15:0] a, input logic [35:0] d, input logic [3:0] bw);
    set_cmd(1'b0, a, bw);
    step();
    set_idle();
    step();
    dq_in = d;
    step();
    dq_in = '0;
  endtask

  task automatic do_read(input string tag, input logic [15:0] a, input logic [35:0] exp,
                         input logic exp_oe);
    set_cmd(1'b1, a, 4'hF);
    step();
    set_idle();
    step();
    step();
    check_eq({tag, " data"}, dq_out, exp);
    check_eq({tag, " oe"}, 36'(dq_oe), 36'(exp_oe));
  endtask

  // Write at edge 0, read of the same word at edge 1, data checked after edge 3.
  task automatic wr_rd(input string tag, input logic [15:0] a, input logic [35:0] d,
                       input logic [3:0] bw, input logic [35:0] exp);
    set_cmd(1'b0, a, bw);
    step();
    set_cmd(1'b1, a, 4'hF);
    step();
    set_idle();
    dq_in = d;
    step();
    dq_in = '0;
    step();
    check_eq(tag, dq_out, exp);
  endtask

  function automatic logic [35:0] pat(input logic [15:0] a);
    return 36'h5A0000000 | 36'(a);
  endfunction

  task automatic burst_read(input string tag, input logic [15:0] base, input logic lbo,
                            input logic [15:0] e0, input logic [15:0] e1,
                            input logic [15:0] e2, input logic [15:0] e3);
    lbo_n = lbo;
    set_cmd(1'b1, base, 4'hF);
    step();
    ld_n = 1'b1;
    step();
    step();
    check_eq({tag, " beat0"}, dq_out, pat(e0));
    step();
    check_eq({tag, " beat1"}, dq_out, pat(e1));
    set_idle();
    step();
    check_eq({tag, " beat2"}, dq_out, pat(e2));
    step();
    check_eq({tag, " beat3"}, dq_out, pat(e3));
    lbo_n = 1'b0;
  endtask

  initial begin
    rst   = 1'b1;
    addr  = '0;
    cke_n = 1'b0;
    ce2   = 1'b1;
    ce2_n = 1'b0;
    lbo_n = 1'b0;
    oe_n  = 1'b0;
    zz    = 1'b0;
    dq_in = '0;
    set_idle();
    step();
    step();
    check_eq("reset dq_out", dq_out, 36'h0);
    check_eq("reset dq_oe", 36'(dq_oe), 36'h0);
    rst = 1'b0;
    step();

    // Plain write then read.
    do_write(16'h0010, 36'h123456789, 4'h0);
    do_read("wr then rd", 16'h0010, 36'h123456789, 1'b1);

    // Back-to-back write/read, full and single-lane masked.
    wr_rd("fwd full", 16'h0020, 36'hAAAAAAAAA, 4'h0, 36'hAAAAAAAAA);
    wr_rd("fwd lane0", 16'h0020, 36'h1FFFFFFFF, 4'hE, 36'hAAAAAABFF);

    // Upper address bits alias.
    do_read("alias", 16'h0410, 36'h123456789, 1'b1);

    // Bursts over words 4..7.
    for (int a = 4; a < 8; a++) do_write(16'(a), pat(16'(a)), 4'h0);
    burst_read("lin base6", 16'h0006, 1'b0, 16'd6, 16'd7, 16'd4, 16'd5);
    burst_read("ilv base6", 16'h0006, 1'b1, 16'd6, 16'd7, 16'd4, 16'd5);
    burst_read("ilv base5", 16'h0005, 1'b1, 16'd5, 16'd4, 16'd7, 16'd6);

    // Read stalled by cke_n for three edges.
    set_cmd(1'b1, 16'h0010, 4'hF);
    step();
    set_idle();
    cke_n = 1'b1;
    step();
    step();
    step();
    check_eq("stall hold data", dq_out, pat(16'd6));
    check_eq("stall hold oe", 36'(dq_oe), 36'h0);
    cke_n = 1'b0;
    step();
    check_eq("stall stage B", dq_out, pat(16'd6));
    step();
    check_eq("stall data", dq_out, 36'h123456789);
    check_eq("stall oe", 36'(dq_oe), 36'h1);

    // Write stalled between stage B and its data edge.
    set_cmd(1'b0, 16'h0030, 4'h0);
    step();
    set_idle();
    step();
    cke_n = 1'b1;
    dq_in = 36'h000000BAD;
    step();
    step();
    step();
    cke_n = 1'b0;
    dq_in = 36'h0CAFEF00D;
    step();
    dq_in = '0;
    do_read("stall write", 16'h0030, 36'h0CAFEF00D, 1'b1);

    // oe_n only gates the enable.
    oe_n = 1'b1;
    do_read("oe_n high", 16'h0020, 36'hAAAAAABFF, 1'b0);
    oe_n = 1'b0;
    #1;
    check_eq("oe_n release", 36'(dq_oe), 36'h1);

    // Deselected write and read.
    set_cmd(1'b0, 16'h0010, 4'h0);
    ce2 = 1'b0;
    step();
    set_idle();
    ce2 = 1'b1;
    step();
    dq_in = 36'hFFFFFFFFF;
    step();
    dq_in = '0;
    do_read("desel write", 16'h0010, 36'h123456789, 1'b1);
    set_cmd(1'b1, 16'h0020, 4'hF);
    ce2 = 1'b0;
    step();
    set_idle();
    ce2 = 1'b1;
    step();
    step();
    check_eq("desel read oe", 36'(dq_oe), 36'h0);
    check_eq("desel read data", dq_out, 36'h123456789);

    // Write command during sleep is dropped.
    set_cmd(1'b0, 16'h0010, 4'h0);
    zz = 1'b1;
    step();
    zz = 1'b0;
    set_idle();
    step();
    dq_in = 36'hFFFFFFFFF;
    step();
    dq_in = '0;
    do_read("zz write", 16'h0010, 36'h123456789, 1'b1);

    // Read in flight when sleep rises completes without driving.
    set_cmd(1'b1, 16'h0020, 4'hF);
    step();
    set_idle();
    zz = 1'b1;
    step();
    step();
    check_eq("zz read data", dq_out, 36'hAAAAAABFF);
    check_eq("zz read oe", 36'(dq_oe), 36'h0);
    zz = 1'b0;
    #1;
    check_eq("zz release oe", 36'(dq_oe), 36'h1);

    // Reset between a write command and its data edge.
    set_cmd(1'b1, 16'h0030, 4'hF);
    step();
    set_cmd(1'b0, 16'h0010, 4'h0);
    step();
    set_idle();
    step();
    check_eq("pre-reset oe", 36'(dq_oe), 36'h1);
    rst = 1'b1;
    #1;
    check_eq("mid reset oe", 36'(dq_oe), 36'h0);
    check_eq("mid reset data", dq_out, 36'h0);
    dq_in = 36'hFEDCBA987;
    step();
    step();
    rst   = 1'b0;
    dq_in = '0;
    step();
    do_read("post reset", 16'h0010, 36'h123456789, 1'b1);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
